// File: rtl/approx_product_accumulator.sv
// -----------------------------------------------------------------------------
// approx_product_accumulator
//
// Back end of the 8x8 approximate multiplier. Products arrive on a valid/ready
// stream and are summed over a frame closed by prod_last. Each frame produces
// one result on a second valid/ready stream: a saturated sum, a saturated beat
// count, a sticky overflow flag and a flag showing whether the accuracy mode
// (prod_mask) changed inside the frame.
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   rst_n       in   synchronous active-low reset
//   prod_in     in   [PROD_W-1:0] unsigned product from the multiplier
//   prod_mask   in   accuracy mode that produced prod_in (1 = approximate)
//   prod_last   in   final product of the frame
//   prod_valid  in   prod_in / prod_mask / prod_last are valid
//   prod_ready  out  block can accept a product this cycle (registered)
//   sum_out     out  [ACC_W-1:0] saturated frame sum
//   sum_count   out  [CNT_W-1:0] saturated number of products in the frame
//   sum_ovf     out  sum or count saturated during the frame
//   sum_moderr  out  prod_mask changed within the frame
//   sum_valid   out  result valid
//   sum_ready   in   downstream accepts the result
// -----------------------------------------------------------------------------
module approx_product_accumulator #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_mask,
    input  logic              prod_last,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  sum_out,
    output logic [CNT_W-1:0]  sum_count,
    output logic              sum_ovf,
    output logic              sum_moderr,
    output logic              sum_valid,
    input  logic              sum_ready
);

    // IDLE: no beat of the current frame seen yet
    // ACCUM: frame open, at least one beat accepted
    // HOLD: result pending on the output stream
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             moderr_q, moderr_d;
    logic             ref_mask_q, ref_mask_d;
    logic             prod_ready_q, prod_ready_d;
    logic [ACC_W-1:0] sum_out_q, sum_out_d;
    logic [CNT_W-1:0] sum_count_q, sum_count_d;
    logic             sum_ovf_q, sum_ovf_d;
    logic             sum_moderr_q, sum_moderr_d;
    logic             sum_valid_q, sum_valid_d;

    // One extra bit on each adder so the carry out flags saturation.
    logic [ACC_W:0]   acc_sum;
    logic [CNT_W:0]   cnt_sum;
    logic [ACC_W-1:0] acc_sat;
    logic [CNT_W-1:0] cnt_sat;
    logic             acc_clip;
    logic             cnt_clip;
    logic             beat_accept;
    logic             mode_mismatch;
    logic             new_ovf;
    logic             new_moderr;

    always_comb begin
        acc_sum  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};
        cnt_sum  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        acc_clip = acc_sum[ACC_W];
        cnt_clip = cnt_sum[CNT_W];
        acc_sat  = acc_clip ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
        cnt_sat  = cnt_clip ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

        beat_accept = prod_valid & prod_ready_q;
        // The first beat defines the reference mode, so it can never mismatch.
        mode_mismatch = (state_q != ST_IDLE) && (prod_mask != ref_mask_q);
        new_ovf       = ovf_q | acc_clip | cnt_clip;
        new_moderr    = moderr_q | mode_mismatch;
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        moderr_d     = moderr_q;
        ref_mask_d   = ref_mask_q;
        sum_out_d    = sum_out_q;
        sum_count_d  = sum_count_q;
        sum_ovf_d    = sum_ovf_q;
        sum_moderr_d = sum_moderr_q;
        sum_valid_d  = sum_valid_q;

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (beat_accept) begin
                    acc_d    = acc_sat;
                    cnt_d    = cnt_sat;
                    ovf_d    = new_ovf;
                    moderr_d = new_moderr;
                    if (state_q == ST_IDLE) begin
                        ref_mask_d = prod_mask;
                    end
                    if (prod_last) begin
                        // Result includes the last beat and is visible next cycle.
                        state_d      = ST_HOLD;
                        sum_out_d    = acc_sat;
                        sum_count_d  = cnt_sat;
                        sum_ovf_d    = new_ovf;
                        sum_moderr_d = new_moderr;
                        sum_valid_d  = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_HOLD: begin
                if (sum_valid_q && sum_ready) begin
                    state_d     = ST_IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    moderr_d    = 1'b0;
                    sum_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                sum_valid_d = 1'b0;
            end
        endcase

        // Registered from the next state so it never combinationally sees sum_ready.
        prod_ready_d = (state_d != ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            moderr_q     <= 1'b0;
            ref_mask_q   <= 1'b0;
            prod_ready_q <= 1'b0;
            sum_out_q    <= '0;
            sum_count_q  <= '0;
            sum_ovf_q    <= 1'b0;
            sum_moderr_q <= 1'b0;
            sum_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            moderr_q     <= moderr_d;
            ref_mask_q   <= ref_mask_d;
            prod_ready_q <= prod_ready_d;
            sum_out_q    <= sum_out_d;
            sum_count_q  <= sum_count_d;
            sum_ovf_q    <= sum_ovf_d;
            sum_moderr_q <= sum_moderr_d;
            sum_valid_q  <= sum_valid_d;
        end
    end

    assign prod_ready = prod_ready_q;
    assign sum_out    = sum_out_q;
    assign sum_count  = sum_count_q;
    assign sum_ovf    = sum_ovf_q;
    assign sum_moderr = sum_moderr_q;
    assign sum_valid  = sum_valid_q;

endmodule

// File: tb/tb_approx_product_accumulator.sv
// Self-checking bench for approx_product_accumulator.
module tb_approx_product_accumulator;

    localparam int unsigned PROD_W = 16;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [PROD_W-1:0] prod_in;
    logic              prod_mask;
    logic              prod_last;
    logic              prod_valid;
    logic              prod_ready;
    logic [ACC_W-1:0]  sum_out;
    logic [CNT_W-1:0]  sum_count;
    logic              sum_ovf;
    logic              sum_moderr;
    logic              sum_valid;
    logic              sum_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    approx_product_accumulator #(
        .PROD_W(PROD_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prod_in   (prod_in),
        .prod_mask (prod_mask),
        .prod_last (prod_last),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .sum_out   (sum_out),
        .sum_count (sum_count),
        .sum_ovf   (sum_ovf),
        .sum_moderr(sum_moderr),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready)
    );

    // Up to four beats per frame; beat b uses v[b] and m[b].
    typedef struct {
        int               n;
        logic [3:0][15:0] v;
        logic [3:0]       m;
        logic [23:0]      es;
        logic [7:0]       ec;
        logic             eo;
        logic             em;
    } frame_t;

    frame_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] v, input logic m, input logic l);
        int k = 0;
        prod_in    = v;
        prod_mask  = m;
        prod_last  = l;
        prod_valid = 1'b1;
        while (!prod_ready && k < 100) begin
            tick();
            k++;
        end
        if (k == 100) chk("prod_ready_timeout", 32'(prod_ready), 32'd1);
        if (l) chk("valid_before_last", 32'(sum_valid), 32'd0);
        tick();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        prod_in    = 16'hdead;
    endtask

    task automatic check_result(input string tag, input logic [23:0] es, input logic [7:0] ec,
                                input logic eo, input logic em);
        chk({tag, "_valid"}, 32'(sum_valid), 32'd1);
        chk({tag, "_ready_low"}, 32'(prod_ready), 32'd0);
        chk({tag, "_sum"}, 32'(sum_out), 32'(es));
        chk({tag, "_count"}, 32'(sum_count), 32'(ec));
        chk({tag, "_ovf"}, 32'(sum_ovf), 32'(eo));
        chk({tag, "_moderr"}, 32'(sum_moderr), 32'(em));
    endtask

    task automatic ack(input string tag);
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        chk({tag, "_ack_valid"}, 32'(sum_valid), 32'd0);
        chk({tag, "_ack_ready"}, 32'(prod_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{3, {16'd0, 16'd1980, 16'd1980, 16'd1980}, 4'b0111, 24'd5940, 8'd3, 1'b0, 1'b0};
        vecs[1] = '{3, {16'd0, 16'd30, 16'd20, 16'd10}, 4'b0101, 24'd60, 8'd3, 1'b0, 1'b1};
        vecs[2] = '{1, {16'd0, 16'd0, 16'd0, 16'd100}, 4'b0000, 24'd100, 8'd1, 1'b0, 1'b0};
        vecs[3] = '{2, {16'd0, 16'd0, 16'd65535, 16'd1}, 4'b0011, 24'd65536, 8'd2, 1'b0, 1'b0};
        vecs[4] = '{4, {16'd4, 16'd3, 16'd2, 16'd1}, 4'b0000, 24'd10, 8'd4, 1'b0, 1'b0};
        vecs[5] = '{2, {16'd0, 16'd0, 16'd6, 16'd5}, 4'b0010, 24'd11, 8'd2, 1'b0, 1'b1};

        rst_n      = 1'b0;
        prod_in    = '0;
        prod_mask  = 1'b0;
        prod_last  = 1'b0;
        prod_valid = 1'b0;
        sum_ready  = 1'b0;

        // Reset held for three clocks.
        repeat (3) tick();
        chk("rst_ready", 32'(prod_ready), 32'd0);
        chk("rst_valid", 32'(sum_valid), 32'd0);
        chk("rst_sum", 32'(sum_out), 32'd0);
        chk("rst_count", 32'(sum_count), 32'd0);
        chk("rst_ovf", 32'(sum_ovf), 32'd0);
        chk("rst_moderr", 32'(sum_moderr), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_release_ready", 32'(prod_ready), 32'd1);
        chk("rst_release_valid", 32'(sum_valid), 32'd0);

        // Table frames; odd entries get a bubble between beats.
        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < vecs[i].n; b++) begin
                send_beat(vecs[i].v[b], vecs[i].m[b], b == vecs[i].n - 1);
                if ((i % 2) == 1 && b < vecs[i].n - 1) begin
                    prod_in = 16'hffff;
                    tick();
                end
            end
            check_result($sformatf("vec%0d", i), vecs[i].es, vecs[i].ec, vecs[i].eo, vecs[i].em);
            ack($sformatf("vec%0d", i));
        end

        // Saturation of both sum and count.
        for (int b = 0; b < 256; b++) send_beat(16'hffff, 1'b0, 1'b0);
        send_beat(16'hffff, 1'b0, 1'b1);
        check_result("sat", 24'd16777215, 8'd255, 1'b1, 1'b0);
        ack("sat");
        send_beat(16'd1, 1'b0, 1'b1);
        check_result("post_sat", 24'd1, 8'd1, 1'b0, 1'b0);
        ack("post_sat");

        // Backpressure: result held, new beats refused.
        send_beat(16'd7, 1'b1, 1'b1);
        check_result("bp_first", 24'd7, 8'd1, 1'b0, 1'b0);
        prod_valid = 1'b1;
        prod_in    = 16'd999;
        prod_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", 32'(sum_valid), 32'd1);
            chk("bp_sum", 32'(sum_out), 32'd7);
            chk("bp_ready", 32'(prod_ready), 32'd0);
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        ack("bp");
        send_beat(16'd100, 1'b0, 1'b1);
        check_result("bp_next", 24'd100, 8'd1, 1'b0, 1'b0);
        ack("bp_next");

        // Reset mid-frame discards the partial sum.
        send_beat(16'd500, 1'b0, 1'b0);
        send_beat(16'd500, 1'b0, 1'b0);
        chk("midrst_no_valid", 32'(sum_valid), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", 32'(sum_valid), 32'd0);
        chk("midrst_sum", 32'(sum_out), 32'd0);
        chk("midrst_ready", 32'(prod_ready), 32'd0);
        tick();
        chk("midrst_ready_back", 32'(prod_ready), 32'd1);
        chk("midrst_valid_back", 32'(sum_valid), 32'd0);
        send_beat(16'd7, 1'b0, 1'b1);
        check_result("midrst", 24'd7, 8'd1, 1'b0, 1'b0);
        ack("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
